// File: rtl/PARAMS_pkg.sv
// PARAMS_pkg: shared word size, loader state encoding and image bus slicing helper.
package PARAMS_pkg;
    localparam int WD_SIZE = 32;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} loader_state_t;

    function automatic int img_word_lsb(input int i);
        return i * WD_SIZE;
    endfunction
endpackage

// File: rtl/prog_loader_hold_cnt.sv
// prog_loader_hold_cnt: loadable down-counter with terminal-count flag, times the post-load reset hold.
module prog_loader_hold_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc = cnt_q == '0;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into the imem init bus and holds the core in reset
// until the image is complete plus a fixed settle time.
module prog_loader
    import PARAMS_pkg::*;
#(
    parameter int WORDS       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WD_SIZE-1:0]       s_data,
    input  logic                     s_last,
    output logic [WORDS*WD_SIZE-1:0] image_o,
    output logic                     core_reset_n,
    output logic                     done,
    output logic                     err_overflow
);
    localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    loader_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WD_SIZE-1:0] img_q [WORDS];
    logic [WD_SIZE-1:0] img_d [WORDS];
    logic               err_q, err_d, run_q, run_d;
    logic               beat, hold_load, hold_tc;

    assign s_ready = state_q == LOAD || state_q == DRAIN;
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        img_d     = img_q;
        err_d     = err_q;
        hold_load = 1'b0;
        case (state_q)
            IDLE, RUN: if (load_start) begin
                state_d = LOAD;
                cnt_d   = '0;
                err_d   = 1'b0;
                img_d   = '{default: '0};
            end
            LOAD: if (beat) begin
                img_d[cnt_q] = s_data;
                cnt_d        = cnt_q + CW'(1);
                if (s_last) begin
                    state_d   = HOLD;
                    hold_load = 1'b1;
                end else if (cnt_q == CW'(WORDS - 1)) begin
                    // Image is full but the stream continues: swallow the rest
                    state_d = DRAIN;
                    err_d   = 1'b1;
                end
            end
            DRAIN: if (beat && s_last) begin
                state_d   = HOLD;
                hold_load = 1'b1;
            end
            HOLD:    state_d = hold_tc ? RUN : HOLD;
            default: state_d = IDLE;
        endcase
        run_d = state_d == RUN;
    end

    prog_loader_hold_cnt #(.W(HW)) u_hold_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .en       (state_q == HOLD),
        .load_val (HW'(HOLD_CYCLES - 1)),
        .tc       (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            img_q   <= '{default: '0};
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            img_q   <= img_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_img
        assign image_o[img_word_lsb(i) +: WD_SIZE] = img_q[i];
    end

    assign core_reset_n = run_q;
    assign done         = run_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven loads with a scoreboard of expected images, plus reset/reload sequences.
module tb_prog_loader;
    logic         clk = 1'b0;
    logic         reset, load_start, s_valid, s_ready, s_last;
    logic         core_reset_n, done, err_overflow;
    logic [31:0]  s_data;
    logic [127:0] image_o;

    always #5 clk = ~clk;

    prog_loader #(.WORDS(4), .HOLD_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .image_o      (image_o),
        .core_reset_n (core_reset_n),
        .done         (done),
        .err_overflow (err_overflow)
    );

    typedef struct {
        logic [5:0][31:0] data;
        int               n;
        logic             gap;
        logic             noise;
        logic [127:0]     img;
        logic             err;
    } vec_t;

    typedef struct {
        logic [127:0] img;
        logic         err;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        exp_t e;
        int   lat;
        t = vecs[v];
        // load_start with a valid beat alongside: the beat must not be taken
        load_start = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b1;
        step;
        load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        chk("start_img", image_o, '0);
        chk("start_flags", {done, core_reset_n, err_overflow, s_ready}, 4'b0001);
        for (int b = 0; b < t.n; b++) begin
            s_valid = 1'b1; s_data = t.data[b]; s_last = (b == t.n - 1); load_start = t.noise;
            chk("beat_ready", s_ready, 1'b1);
            if (b == t.n - 1) sb.push_back('{t.img, t.err});
            step;
            s_valid = 1'b0; s_last = 1'b0; load_start = 1'b0; s_data = $urandom;
            if (t.gap && b != t.n - 1) begin
                chk("gap_ready", s_ready, 1'b1);
                step;
            end
        end
        load_start = t.noise;
        step;
        load_start = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            step;
            lat++;
        end
        chk("latency", lat, 2);
        e = sb.pop_front();
        chk("image", image_o, e.img);
        chk("err", err_overflow, e.err);
        chk("run_flags", {done, core_reset_n, s_ready}, 3'b110);
    endtask

    initial begin
        vecs[0] = '{data: {32'h0, 32'h0, 32'h00310193, 32'h00208113, 32'h00100093, 32'h00000013},
                    n: 4, gap: 1'b0, noise: 1'b0,
                    img: {32'h00310193, 32'h00208113, 32'h00100093, 32'h00000013}, err: 1'b0};
        vecs[1] = '{data: {32'h0, 32'h0, 32'h0, 32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA},
                    n: 2, gap: 1'b0, noise: 1'b1,
                    img: {32'h0, 32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA}, err: 1'b0};
        vecs[2] = '{data: {32'h60000006, 32'h50000005, 32'h40000004, 32'h30000003, 32'h20000002, 32'h10000001},
                    n: 6, gap: 1'b0, noise: 1'b1,
                    img: {32'h40000004, 32'h30000003, 32'h20000002, 32'h10000001}, err: 1'b1};
        vecs[3] = '{data: {32'h0, 32'h0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    n: 4, gap: 1'b1, noise: 1'b0,
                    img: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, err: 1'b0};

        reset = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        step;
        step;
        chk("rst_img", image_o, '0);
        chk("rst_flags", {done, core_reset_n, err_overflow, s_ready}, 4'b0000);
        reset = 1'b0;
        step;
        chk("idle_ready", s_ready, 1'b0);

        for (int v = 0; v < 4; v++) run_vec(v);

        load_start = 1'b1;
        step;
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'hAAAAAAAA;
        step;
        s_data = 32'hBBBBBBBB;
        step;
        s_valid = 1'b0;
        chk("partial_img", image_o, {64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA});
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("midrst_img", image_o, '0);
        chk("midrst_flags", {done, core_reset_n, err_overflow, s_ready}, 4'b0000);
        step;
        chk("midrst_idle", s_ready, 1'b0);
        run_vec(0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
